clk_div_multi: RTL and testbench

Multi-channel programmable clock/tick divider. Each channel divides in_clk by a runtime-loadable terminal count. Each channel outputs a 50% square wave (div_clk) and a one-cycle strobe (tick). Serves as the shared timebase for game-logic, display-refresh and debounce timers. Terminal-count changes take effect glitch-free at the end of the current period.

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_chan.sv | 75 +++++++
 rtl/clk_div_multi.sv | 47 ++++
 tb/tb_clk_div_multi.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package clk_div_pkg;

  localparam int     CNT_W_DEF       = 33;
  localparam longint DEFAULT_MAX_DEF = 64'd7499999;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow terminal count, square wave and tick.
// Latency: tick and div_clk edge appear one in_clk after count reaches max_active.
// Backpressure: none; en freezes the channel, a stopped channel adopts a pending max at once.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_MAX = CNT_W'(DEFAULT_MAX_DEF)
) (
  input  logic             in_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             div_clk,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] max_active;
  logic [CNT_W-1:0] max_shadow;
  logic             term;

  // >= rather than == so a count left above a freshly shrunk max still ends the period.
  assign term = (count >= max_active);

  // Counter, output and terminal-count update; sync outranks the normal run logic.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      div_clk    <= 1'b0;
      tick       <= 1'b0;
      max_active <= DEFAULT_MAX;
      max_shadow <= DEFAULT_MAX;
      pending    <= 1'b0;
    end else if (sync) begin
      count   <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
      // The shadow held before this cycle is applied; a same-cycle write is queued behind it.
      if (pending) max_active <= max_shadow;
      pending <= wr;
      if (wr) max_shadow <= wr_val;
    end else if (en && term) begin
      count   <= '0;
      div_clk <= ~div_clk;
      tick    <= 1'b1;
      if (wr) begin
        // Write landing on the period boundary governs the very next period.
        max_active <= wr_val;
        max_shadow <= wr_val;
        pending    <= 1'b0;
      end else if (pending) begin
        max_active <= max_shadow;
        pending    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
      if (en) begin
        count <= count + CNT_W'(1);
      end else if (pending) begin
        max_active <= max_shadow;
      end
      if (wr) begin
        max_shadow <= wr_val;
        pending    <= 1'b1;
      end else if (!en) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable divider: NUM_CH independent square-wave/tick timebases.
// Latency: first tick max+1 enabled cycles after reset or sync; config applies at period end.
// Backpressure: none; writes to channel indices >= NUM_CH are dropped.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int               NUM_CH      = 4,
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_MAX = CNT_W'(DEFAULT_MAX_DEF)
) (
  input  logic                        in_clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           en,
  input  logic                        sync,
  input  logic                        cfg_we,
  input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]            cfg_max,
  output logic [NUM_CH-1:0]           div_clk,
  output logic [NUM_CH-1:0]           tick,
  output logic [NUM_CH-1:0]           cfg_pending
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] wr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range indices match no channel, so such writes vanish.
    assign wr[i] = cfg_we && (cfg_ch == CH_W'(i));

    clk_div_chan #(
      .CNT_W      (CNT_W),
      .DEFAULT_MAX(DEFAULT_MAX)
    ) u_chan (
      .in_clk (in_clk),
      .rst_n  (rst_n),
      .en     (en[i]),
      .sync   (sync),
      .wr     (wr[i]),
      .wr_val (cfg_max),
      .div_clk(div_clk[i]),
      .tick   (tick[i]),
      .pending(cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus random traffic vs. a period model.
// Latency: outputs compared on the falling edge after each rising edge.
// Backpressure: n/a.
module tb_clk_div_multi;

  // Three channels so that cfg_ch=3 fits the 2-bit select yet addresses no channel.
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 33;
  localparam int DMAX   = 3;
  localparam int CH_W   = clk_div_pkg::ch_idx_w(NUM_CH);

  logic              in_clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_max;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] cfg_pending;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_multi #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEFAULT_MAX(CNT_W'(DMAX))
  ) dut (
    .in_clk     (in_clk),
    .rst_n      (rst_n),
    .en         (en),
    .sync       (sync),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_max    (cfg_max),
    .div_clk    (div_clk),
    .tick       (tick),
    .cfg_pending(cfg_pending)
  );

  always #5 in_clk = ~in_clk;

  // Reference: each channel runs periods of (limit+1) enabled cycles; "done" is how many
  // enabled cycles of the current period have elapsed, "half" is the square-wave level.
  longint m_done  [NUM_CH];
  longint m_limit [NUM_CH];
  longint m_next  [NUM_CH];
  bit     m_queued[NUM_CH];
  bit     m_half  [NUM_CH];
  bit     m_pulse [NUM_CH];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_done[c]   = 0;
      m_limit[c]  = DMAX;
      m_next[c]   = DMAX;
      m_queued[c] = 0;
      m_half[c]   = 0;
      m_pulse[c]  = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      bit     hit;
      longint v;
      hit = cfg_we && (int'(cfg_ch) == c);
      v   = longint'(cfg_max);
      m_pulse[c] = 0;
      if (sync) begin
        if (m_queued[c]) m_limit[c] = m_next[c];
        m_queued[c] = 0;
        m_done[c]   = 0;
        m_half[c]   = 0;
        if (hit) begin m_next[c] = v; m_queued[c] = 1; end
      end else if (en[c] && m_done[c] + 1 > m_limit[c]) begin
        // period complete: new period starts, wave flips, strobe fires
        m_done[c]  = 0;
        m_half[c]  = !m_half[c];
        m_pulse[c] = 1;
        if (hit) begin m_limit[c] = v; m_next[c] = v; m_queued[c] = 0; end
        else if (m_queued[c]) begin m_limit[c] = m_next[c]; m_queued[c] = 0; end
      end else begin
        if (en[c]) m_done[c] = m_done[c] + 1;
        else if (m_queued[c]) begin m_limit[c] = m_next[c]; m_queued[c] = 0; end
        if (hit) begin m_next[c] = v; m_queued[c] = 1; end
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    logic [NUM_CH-1:0] e_clk, e_tick, e_pend;
    for (int c = 0; c < NUM_CH; c++) begin
      e_clk[c]  = m_half[c];
      e_tick[c] = m_pulse[c];
      e_pend[c] = m_queued[c];
    end
    check("div_clk", 64'(div_clk), 64'(e_clk));
    check("tick", 64'(tick), 64'(e_tick));
    check("cfg_pending", 64'(cfg_pending), 64'(e_pend));
  endtask

  task automatic step();
    @(posedge in_clk);
    model_edge();
    @(negedge in_clk);
    compare_model();
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = '0;
    sync    = 1'b0;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_max = '0;
    model_reset();
    repeat (2) @(negedge in_clk);
    check("reset div_clk", 64'(div_clk), 64'd0);
    check("reset tick", 64'(tick), 64'd0);
    check("reset pending", 64'(cfg_pending), 64'd0);

    // Default max 3: ticks on enabled cycles 4, 8, 12.
    rst_n = 1'b1;
    en    = '1;
    for (int k = 1; k <= 13; k++) begin
      step();
      check($sformatf("default tick c%0d", k), 64'(tick[0]), 64'((k % 4) == 0));
    end

    // ch0 now at count 1: shrink to max 1, current period still ends at 3.
    cfg_we = 1'b1; cfg_ch = 0; cfg_max = 1;
    step();
    cfg_we = 1'b0;
    check("shrink pending", 64'(cfg_pending[0]), 64'd1);
    step();
    step();
    check("shrink apply tick", 64'(tick[0]), 64'd1);
    check("shrink apply pending", 64'(cfg_pending[0]), 64'd0);
    repeat (6) step();

    // ch1 to max 0: toggles every cycle, tick held high.
    cfg_we = 1'b1; cfg_ch = 1; cfg_max = 0;
    step();
    cfg_we = 1'b0;
    repeat (8) step();
    check("max0 tick", 64'(tick[1]), 64'd1);

    // Freeze ch0 for five cycles.
    en = 3'b110;
    repeat (5) step();
    en = '1;
    repeat (6) step();

    // sync with a same-cycle write to ch0.
    sync = 1'b1; cfg_we = 1'b1; cfg_ch = 0; cfg_max = 2;
    step();
    sync = 1'b0; cfg_we = 1'b0;
    check("sync div_clk", 64'(div_clk), 64'd0);
    check("sync tick", 64'(tick), 64'd0);
    check("sync pending", 64'(cfg_pending), 64'b001);
    repeat (10) step();

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      en      = NUM_CH'($urandom_range(0, 7) | ($urandom_range(0, 3) != 0 ? 7 : 0));
      sync    = ($urandom_range(0, 49) == 0);
      cfg_we  = ($urandom_range(0, 7) == 0);
      cfg_ch  = CH_W'($urandom_range(0, 3));
      cfg_max = CNT_W'($urandom_range(0, 6));
      step();
    end
    sync = 1'b0; cfg_we = 1'b0; en = '1;
    repeat (5) step();

    // Asynchronous reset between edges, with an out-of-range write around it.
    @(posedge in_clk);
    model_edge();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async div_clk", 64'(div_clk), 64'd0);
    check("async tick", 64'(tick), 64'd0);
    check("async pending", 64'(cfg_pending), 64'd0);
    cfg_we = 1'b1; cfg_ch = 3; cfg_max = 0;
    @(negedge in_clk);
    rst_n = 1'b1;
    step();
    cfg_we = 1'b0;
    check("bad ch pending", 64'(cfg_pending), 64'd0);
    for (int k = 2; k <= 12; k++) begin
      step();
      check($sformatf("post-reset tick c%0d", k), 64'(tick[2]), 64'((k % 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
